// File: rtl/svm_multiclass_engine.sv
// Multiclass linear-kernel SVM decision engine: streams model rows from an external
// memory and produces one decision bit per binary classifier for each feature vector.
module svm_multiclass_engine #(
  parameter int NBITS     = 5,
  parameter int F_WIDTH   = 8,
  parameter int SUP_WIDTH = 16,
  parameter int NUM_CLS   = 2,
  localparam int ROW_W  = NBITS * (F_WIDTH + 1),
  localparam int R      = NUM_CLS * (SUP_WIDTH + 1),
  localparam int ADDR_W = $clog2(R),
  localparam int ACC_W  = 3 * NBITS + $clog2(F_WIDTH) + $clog2(SUP_WIDTH) + 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NBITS*F_WIDTH-1:0]   in_features,
  input  logic                       fin_valid,
  output logic                       fin_ready,
  output logic                       mem_ren,
  output logic [ADDR_W-1:0]          mem_addr,
  input  logic [ROW_W-1:0]           mem_rdata,
  output logic [NUM_CLS-1:0]         dout_labels,
  output logic                       dout_valid,
  input  logic                       dout_ready,
  output logic [1:0]                 fsm_state
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
  // dout_valid/dout_labels hold until accepted, and fin_ready may depend on dout_ready.

  localparam int DOT_W  = 2 * NBITS + $clog2(F_WIDTH);
  localparam int TERM_W = NBITS + DOT_W;
  localparam int ROWC_W = $clog2(SUP_WIDTH + 1);
  localparam int CLS_W  = (NUM_CLS > 1) ? $clog2(NUM_CLS) : 1;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(R - 1);
  localparam logic [ROWC_W-1:0] LAST_ROW  = ROWC_W'(SUP_WIDTH);

  if (ROW_W < ACC_W) begin : g_width_check
    $error("svm_multiclass_engine: ROW_W must be >= ACC_W");
  end

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN, OUT} state_t;
  state_t state, state_next;

  logic [NBITS*F_WIDTH-1:0] feat_q;
  logic [ADDR_W-1:0]        addr_q;
  logic                     rvalid_q;
  logic [ROWC_W-1:0]        ret_row;
  logic [CLS_W-1:0]         ret_cls;
  logic signed [ACC_W-1:0]  acc, acc_next;
  logic fire;

  assign fire      = fin_valid && fin_ready;
  assign fsm_state = state;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (fire) state_next = FETCH;
      FETCH:   if (addr_q == LAST_ADDR) state_next = DRAIN;
      DRAIN:   state_next = OUT;
      OUT:     if (dout_ready) state_next = fin_valid ? FETCH : IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    fin_ready  = !rst && (state == IDLE || (state == OUT && dout_ready));
    mem_ren    = (state == FETCH);
    mem_addr   = mem_ren ? addr_q : '0;
    dout_valid = (state == OUT);
  end

  // Score contribution of the row returned this cycle; the first row of a class is its intercept.
  logic signed [NBITS-1:0]   fa, sa, alpha;
  logic signed [2*NBITS-1:0] prod;
  logic signed [DOT_W-1:0]   dot;
  logic signed [TERM_W-1:0]  term;
  logic signed [ACC_W-1:0]   icpt;

  always_comb begin
    fa   = '0;
    sa   = '0;
    prod = '0;
    dot  = '0;
    for (int f = 0; f < F_WIDTH; f++) begin
      fa   = feat_q[NBITS*f +: NBITS];
      sa   = mem_rdata[NBITS*f +: NBITS];
      prod = fa * sa;
      dot  = dot + DOT_W'(prod);
    end
    alpha    = mem_rdata[NBITS*F_WIDTH +: NBITS];
    term     = alpha * dot;
    icpt     = mem_rdata[ACC_W-1:0];
    acc_next = (ret_row == '0) ? icpt : acc + ACC_W'(term);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      feat_q      <= '0;
      addr_q      <= '0;
      rvalid_q    <= 1'b0;
      ret_row     <= '0;
      ret_cls     <= '0;
      acc         <= '0;
      dout_labels <= '0;
    end else begin
      rvalid_q <= mem_ren;
      if (fire) begin
        feat_q  <= in_features;
        addr_q  <= '0;
        ret_row <= '0;
        ret_cls <= '0;
      end else if (state == FETCH) begin
        addr_q <= addr_q + ADDR_W'(1);
      end
      if (rvalid_q) begin
        acc <= acc_next;
        if (ret_row == LAST_ROW) begin
          ret_row              <= '0;
          ret_cls              <= ret_cls + CLS_W'(1);
          dout_labels[ret_cls] <= !acc_next[ACC_W-1];
        end else begin
          ret_row <= ret_row + ROWC_W'(1);
        end
      end
    end
  end

endmodule
